// File: rtl/adc_sample_capture.sv
// adc_sample_capture: pre/post-trigger window capture behind the AD9228
// deserializer. Samples land in a circular buffer; a threshold crossing or a
// forced trigger freezes a DEPTH-sample window, which is then drained in time
// order over a valid/ready stream. Everything runs on the deserializer word clock.
module adc_sample_capture #(
   parameter int DATA_WIDTH  = 12,
   parameter int DEPTH       = 64,
   parameter int PRE_SAMPLES = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] des_data,
   input  logic                  read_complete,
   input  logic                  arm,
   input  logic                  force_trig,
   input  logic                  trig_rising,
   input  logic [DATA_WIDTH-1:0] threshold,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PRE_A     = AW'(PRE_SAMPLES);
   localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE_SAMPLES - 1);
   localparam logic [AW:0]   BEATS     = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LAST_BEAT = (AW+1)'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRETRIG,
      ARMED,
      POSTTRIG,
      READOUT
   } state_t;

   state_t state;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         trig_ptr;
   logic [AW-1:0]         pre_cnt;
   logic [AW-1:0]         post_cnt;
   logic [AW:0]           issue_cnt;
   logic [DATA_WIDTH-1:0] prev_sample;
   logic                  rc_prev;

   logic accept;
   logic capturing;
   logic wr_en;
   logic crossing;
   logic trig_hit;

   // Edge-detect the deserializer flag and evaluate the trigger on accepted samples
   always_comb begin
      accept    = read_complete & ~rc_prev;
      capturing = (state == PRETRIG) || (state == ARMED) || (state == POSTTRIG);
      wr_en     = rstn & accept & capturing;
      if (trig_rising) begin
         crossing = (prev_sample < threshold) && (des_data >= threshold);
      end else begin
         crossing = (prev_sample > threshold) && (des_data <= threshold);
      end
      trig_hit = accept && (state == ARMED) && (force_trig || crossing);
   end

   assign busy = (state != IDLE);

   // Sample buffer write port, kept reset-free so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= des_data;
      end
   end

   // Capture/readout state machine with registered stream outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         trig_ptr    <= '0;
         pre_cnt     <= '0;
         post_cnt    <= '0;
         issue_cnt   <= '0;
         prev_sample <= '0;
         rc_prev     <= 1'b0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         done        <= 1'b0;
      end else begin
         rc_prev <= read_complete;
         done    <= 1'b0;

         if (accept && (state != IDLE)) begin
            prev_sample <= des_data;
         end
         if (accept && capturing) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         case (state)
            IDLE: begin
               if (arm) begin
                  wr_ptr  <= '0;
                  pre_cnt <= '0;
                  state   <= PRETRIG;
               end
            end

            PRETRIG: begin
               if (accept) begin
                  pre_cnt <= pre_cnt + 1'b1;
                  if (pre_cnt == PRE_A - 1'b1) begin
                     state <= ARMED;
                  end
               end
            end

            ARMED: begin
               if (trig_hit) begin
                  trig_ptr <= wr_ptr;
                  post_cnt <= POST_INIT;
                  if (POST_INIT == '0) begin
                     rd_ptr    <= wr_ptr - PRE_A;
                     issue_cnt <= '0;
                     state     <= READOUT;
                  end else begin
                     state <= POSTTRIG;
                  end
               end
            end

            POSTTRIG: begin
               if (accept) begin
                  post_cnt <= post_cnt - 1'b1;
                  if (post_cnt == AW'(1)) begin
                     rd_ptr    <= trig_ptr - PRE_A;
                     issue_cnt <= '0;
                     state     <= READOUT;
                  end
               end
            end

            READOUT: begin
               if (done) begin
                  state <= IDLE;
               end else if ((!m_valid || m_ready) && (issue_cnt != BEATS)) begin
                  m_data    <= mem[rd_ptr];
                  m_valid   <= 1'b1;
                  m_last    <= (issue_cnt == LAST_BEAT);
                  rd_ptr    <= rd_ptr + 1'b1;
                  issue_cnt <= issue_cnt + 1'b1;
               end else if (m_valid && m_ready) begin
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  done    <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sample_capture.sv
// tb_adc_sample_capture: scoreboard bench for adc_sample_capture. Each capture
// computes the expected window from its own stimulus list, queues it, and pops
// entries as the DUT streams beats out.
module tb_adc_sample_capture;

   localparam int DW    = 12;
   localparam int DEPTH = 64;
   localparam int PRE   = 16;

   logic          clk;
   logic          rstn;
   logic [DW-1:0] des_data;
   logic          read_complete;
   logic          arm;
   logic          force_trig;
   logic          trig_rising;
   logic [DW-1:0] threshold;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          busy;
   logic          done;

   logic [DW-1:0] stim [0:399];
   logic [DW-1:0] expQ [$];
   int            total;
   int            bad;

   adc_sample_capture #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .PRE_SAMPLES(PRE)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .des_data     (des_data),
      .read_complete(read_complete),
      .arm          (arm),
      .force_trig   (force_trig),
      .trig_rising  (trig_rising),
      .threshold    (threshold),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last),
      .busy         (busy),
      .done         (done)
   );

   // Free-running word clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int findTrigger(int count, int forceIdx, logic [DW-1:0] thr, logic rising);
      for (int i = PRE; i < count; i++) begin
         if (i >= forceIdx) return i;
         if (rising && (stim[i-1] < thr) && (stim[i] >= thr)) return i;
         if (!rising && (stim[i-1] > thr) && (stim[i] <= thr)) return i;
      end
      return -1;
   endfunction

   task automatic pulseReset();
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic pulseArm();
      @(posedge clk); #1;
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic applyStimulus(input int count, input int slowWords, input int forceIdx);
      for (int i = 0; i < count; i++) begin
         des_data      = stim[i];
         force_trig    = (i >= forceIdx);
         read_complete = 1'b1;
         repeat ((i < slowWords) ? 5 : 1) begin
            @(posedge clk); #1;
         end
         read_complete = 1'b0;
         @(posedge clk); #1;
      end
      force_trig = 1'b0;
   endtask

   task automatic collectWindow(input bit randReady);
      int            beats;
      int            cyc;
      logic [DW-1:0] expv;
      beats = 0;
      cyc   = 0;
      while ((beats < DEPTH) && (cyc < 4000)) begin
         @(posedge clk); #1;
         m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         cyc++;
         checkOutput("noEarlyDone", done, 0);
         if (m_valid) begin
            expv = (expQ.size() > 0) ? expQ[0] : '0;
            checkOutput("data", m_data, expv);
            checkOutput("last", m_last, (beats == DEPTH - 1));
            if (m_ready) begin
               if (expQ.size() > 0) void'(expQ.pop_front());
               beats++;
            end
         end
      end
      checkOutput("beatCount", beats, DEPTH);
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(negedge clk);
      checkOutput("donePulse", done, 1);
      checkOutput("validOff", m_valid, 0);
      @(negedge clk);
      checkOutput("doneOnce", done, 0);
      checkOutput("idleBusy", busy, 0);
   endtask

   task automatic runCapture(input int count, input int slowWords, input int forceIdx,
                             input logic [DW-1:0] thr, input logic rising, input bit randReady);
      int t;
      t = findTrigger(count, forceIdx, thr, rising);
      if ((t < 0) || (t + DEPTH - PRE > count)) begin
         $display("[TB] FAIL stimulus has no complete window");
         $fatal(1, "[TB] aborting");
      end
      expQ.delete();
      for (int k = t - PRE; k < t + DEPTH - PRE; k++) expQ.push_back(stim[k]);
      threshold   = thr;
      trig_rising = rising;
      pulseArm();
      fork
         applyStimulus(count, slowWords, forceIdx);
         collectWindow(randReady);
      join
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rstn          = 1'b0;
      des_data      = '0;
      read_complete = 1'b0;
      arm           = 1'b0;
      force_trig    = 1'b0;
      trig_rising   = 1'b1;
      threshold     = '0;
      m_ready       = 1'b1;

      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstValid", m_valid, 0);
      checkOutput("rstLast", m_last, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstData", m_data, 0);

      $display("[TB] ramp, rising trigger at 100");
      for (int i = 0; i < 400; i++) stim[i] = DW'(i);
      runCapture(160, 0, 1000, 12'd100, 1'b1, 1'b0);

      $display("[TB] slow read_complete, pre count boundary");
      runCapture(100, 40, 40, 12'd15, 1'b1, 1'b0);

      $display("[TB] falling trigger on descending samples");
      for (int i = 0; i < 400; i++) stim[i] = DW'(12'hFF0 - 16 * (i % 200));
      runCapture(180, 0, 1000, 12'h800, 1'b0, 1'b0);

      $display("[TB] crossing in pre-trigger, forced trigger after wrap");
      for (int i = 0; i < 400; i++) stim[i] = DW'(i & 8'h7F);
      stim[5] = 12'hFFF;
      runCapture(260, 0, 200, 12'h100, 1'b1, 1'b0);

      $display("[TB] random ready with samples arriving during readout");
      for (int i = 0; i < 400; i++) stim[i] = DW'(i);
      runCapture(300, 0, 1000, 12'd200, 1'b1, 1'b1);

      $display("[TB] reset during post-trigger");
      threshold   = 12'd50;
      trig_rising = 1'b1;
      pulseArm();
      applyStimulus(70, 0, 1000);
      @(negedge clk);
      checkOutput("postBusy", busy, 1);
      checkOutput("postValid", m_valid, 0);
      pulseReset();
      @(negedge clk);
      checkOutput("rst1Busy", busy, 0);
      checkOutput("rst1Valid", m_valid, 0);
      checkOutput("rst1Done", done, 0);

      $display("[TB] reset during readout");
      m_ready = 1'b0;
      pulseArm();
      applyStimulus(120, 0, 1000);
      @(negedge clk);
      checkOutput("stallValid", m_valid, 1);
      checkOutput("stallData", m_data, 34);
      checkOutput("stallLast", m_last, 0);
      checkOutput("stallBusy", busy, 1);
      pulseReset();
      m_ready = 1'b1;
      @(negedge clk);
      checkOutput("rst2Busy", busy, 0);
      checkOutput("rst2Valid", m_valid, 0);
      checkOutput("rst2Done", done, 0);

      $display("[TB] fresh capture after reset");
      for (int i = 0; i < 400; i++) stim[i] = DW'(500 + i);
      runCapture(170, 0, 1000, 12'd600, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Stage directly downstream of the AD9228 deserializer core. Consumes its parallel word `des_data` and completion flag `read_complete`.
- Captures a pre/post-trigger window of samples into an internal circular buffer. Trigger is a threshold crossing or a forced trigger.
- Drains the window in time order over a valid/ready stream to the readout/packetizer logic.
- Runs entirely in the deserializer's word-clock domain.

Parameters:
- DATA_WIDTH, 12: sample width; matches the deserializer output.
- DEPTH, 64: total samples per capture window. Power of two, ≥4.
- PRE_SAMPLES, 16: samples stored before the trigger sample. Valid range 1..DEPTH-2.

Ports:
- clk  in  1  word clock, same clock as the deserializer.
- rstn  in  1  synchronous active-low reset.
- des_data  in  DATA_WIDTH  deserialized sample, offset binary.
- read_complete  in  1  high when des_data holds a new word; may stay high more than 1 cycle.
- arm  in  1  1-cycle pulse; starts a capture.
- force_trig  in  1  level; triggers unconditionally while in ARMED.
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- threshold  in  DATA_WIDTH  trigger level, unsigned compare.
- m_data  out  DATA_WIDTH  readout sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts m_data.
- m_last  out  1  marks the final sample of the window.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse after the last readout beat.

Behaviour:
- Sample accept: on the 0→1 transition of `read_complete`, using an internal registered copy of the previous value.
  - Exactly one accepted sample per rising edge, regardless of high duration.
  - des_data is sampled in the cycle the edge is detected.
- Reset (rstn=0 at a clk edge): state=IDLE. All outputs 0. Pointers, counters, prev register and edge register cleared. Applies mid-capture or mid-readout; the partial window is discarded.
- States: IDLE, PRETRIG, ARMED, POSTTRIG, READOUT.
- IDLE: accepted samples ignored. On arm=1: clear wr_ptr and pre counter, go to PRETRIG. arm is ignored in every other state.
- PRETRIG: each accepted sample is written at wr_ptr, then wr_ptr increments modulo DEPTH and the pre counter increments. When the pre counter reaches PRE_SAMPLES, go to ARMED. Triggers are ignored in this state.
- ARMED: each accepted sample is written circularly (buffer may wrap any number of times). Trigger condition, evaluated only on accepted samples:
  - rising: prev < threshold and cur ≥ threshold.
  - falling: prev > threshold and cur ≤ threshold.
  - force_trig=1 also triggers on an accepted sample.
- prev register: holds the last accepted sample; updated on every accepted sample outside IDLE.
- On trigger:
  - The trigger sample is written.
  - trig_ptr = its address.
  - post counter = DEPTH-PRE_SAMPLES-1.
  - Go to POSTTRIG, or directly to READOUT if the post counter is 0.
- POSTTRIG: write accepted samples and decrement the post counter. When it reaches 0, go to READOUT with rd_ptr = (trig_ptr - PRE_SAMPLES) mod DEPTH.
- READOUT: accepted samples ignored (dropped, not buffered). DEPTH beats in address order starting at rd_ptr, wrapping modulo DEPTH.
  - Buffer read has 1-cycle latency; m_valid first rises 1 cycle after entering READOUT.
  - A beat transfers when m_valid & m_ready. m_data and m_last stay stable while m_valid & !m_ready.
  - m_last=1 only on beat DEPTH. Back-to-back beats with m_ready held high (throughput 1/cycle).
  - After the last beat: m_valid=0, done=1 for one cycle, state=IDLE.
- Window content: exactly PRE_SAMPLES samples before the trigger sample, the trigger sample, and DEPTH-PRE_SAMPLES-1 samples after it.
- Simultaneous events: force_trig together with a threshold crossing gives a single trigger. An arm pulse in the same cycle as done is ignored (state still READOUT).
- Buffer: DEPTH×DATA_WIDTH; inferred RAM or registers, synchronous write and synchronous read.

Test Plan:
- Defaults; arm; feed ramp 0,1,2,… with threshold=100, trig_rising=1 → trigger at sample 100; readout m_data = 84..147, 64 beats, m_last on value 147, done pulses once.
- read_complete held high 5 cycles per word, 40 ramp words, PRE_SAMPLES=16 → exactly 40 writes; pre counter completes on word 16, not earlier.
- trig_rising=0, threshold=0x800, samples 0xFFF…0x000 descending by 0x10 → trigger on first sample ≤0x800 (0x800); it appears at readout beat 17.
- Crossing occurs during PRETRIG (sample 5 = 0xFFF, threshold 0x100) → no trigger. force_trig asserted at ARMED sample 200 → window holds samples 184..247 after buffer wrap.
- Random m_ready (50%) during readout → m_data/m_last unchanged while stalled; 64 beats in order; ARMED/POSTTRIG samples arriving during READOUT not stored.
- rstn=0 for 1 cycle during POSTTRIG and again mid-READOUT → next cycle busy=0, m_valid=0, done=0; a subsequent arm yields a correct fresh capture.
